// File: rtl/cceip_kernel_pkg.sv
// Shared types and constants for the CCEIP kernel write-path arbiter.
package cceip_kernel_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_XFER   = 2'd2,
        S_DONE   = 2'd3
    } wr_state_e;

    // Bytes carried by one beat of the default 64-bit write-data stream.
    localparam int BYTES_PER_BEAT = 8;

    function automatic int bytes_per_beat(input int data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/cceip_kernel_rr_pick.sv
// Round-robin picker: first requester at or after ptr_i, wrapping around.
module cceip_kernel_rr_pick #(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
    output logic [NUM_REQ-1:0]         gnt_o,
    output logic [$clog2(NUM_REQ)-1:0] idx_o,
    output logic                       any_o
);

    localparam int GW = $clog2(NUM_REQ);

    always_comb begin
        int  j;
        logic found;
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        j     = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            j = (int'(ptr_i) + i) % NUM_REQ;
            if (!found && req_i[j]) begin
                found    = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = GW'(j);
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/cceip_kernel_wr_arbiter.sv
// Round-robin arbiter sharing one AXI write master between NUM_REQ requesters,
// forwarding at most ceil(size/bytes-per-beat) beats per granted job.
module cceip_kernel_wr_arbiter
    import cceip_kernel_pkg::*;
#(
    parameter int NUM_REQ           = 2,
    parameter int C_ADDR_WIDTH      = 64,
    parameter int C_XFER_SIZE_WIDTH = 64,
    parameter int C_DATA_WIDTH      = BYTES_PER_BEAT * 8
) (
    input  logic                                ap_clk,
    input  logic                                areset,
    input  logic [NUM_REQ-1:0]                  req_valid,
    output logic [NUM_REQ-1:0]                  req_ready,
    input  logic [NUM_REQ*C_ADDR_WIDTH-1:0]     req_addr,
    input  logic [NUM_REQ*C_XFER_SIZE_WIDTH-1:0] req_size,
    output logic [NUM_REQ-1:0]                  req_done,
    input  logic [NUM_REQ-1:0]                  s_axis_tvalid,
    output logic [NUM_REQ-1:0]                  s_axis_tready,
    input  logic [NUM_REQ*C_DATA_WIDTH-1:0]     s_axis_tdata,
    output logic                                wm_start,
    output logic [C_ADDR_WIDTH-1:0]             wm_addr,
    output logic [C_XFER_SIZE_WIDTH-1:0]        wm_size,
    input  logic                                wm_done,
    output logic                                wm_tvalid,
    input  logic                                wm_tready,
    output logic [C_DATA_WIDTH-1:0]             wm_tdata,
    output logic                                busy,
    output logic [$clog2(NUM_REQ)-1:0]          grant_id
);

    localparam int GW      = $clog2(NUM_REQ);
    localparam int SW      = C_XFER_SIZE_WIDTH;
    localparam int BPB     = bytes_per_beat(C_DATA_WIDTH);
    localparam int BPB_LOG = $clog2(BPB);
    localparam logic [SW-1:0] BPB_MASK = SW'(BPB - 1);

    wr_state_e               state_q;
    logic [GW-1:0]           rr_ptr_q, rr_ptr_d;
    logic [GW-1:0]           grant_q;
    logic [C_ADDR_WIDTH-1:0] addr_q;
    logic [SW-1:0]           size_q;
    logic [SW-1:0]           beats_q, beats_d;
    logic [SW-1:0]           beat_cnt_q, beat_cnt_d;
    logic                    wm_start_q;

    logic [NUM_REQ-1:0]      pick_gnt;
    logic [GW-1:0]           pick_idx;
    logic                    pick_any;
    logic                    accept;
    logic [C_ADDR_WIDTH-1:0] sel_addr;
    logic [SW-1:0]           sel_size;
    logic                    in_xfer;
    logic                    room;
    logic                    beat_fire;

    cceip_kernel_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_pick (
        .req_i (req_valid),
        .ptr_i (rr_ptr_q),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    // The picker only grants valid requesters, so a grant in S_IDLE is an acceptance.
    always_comb begin
        accept   = (state_q == S_IDLE) && pick_any;
        sel_addr = req_addr[int'(pick_idx)*C_ADDR_WIDTH +: C_ADDR_WIDTH];
        sel_size = req_size[int'(pick_idx)*SW +: SW];
        beats_d  = (sel_size >> BPB_LOG) + SW'(|(sel_size & BPB_MASK));
        rr_ptr_d = (grant_q == GW'(NUM_REQ - 1)) ? '0 : grant_q + GW'(1);
    end

    // Beats beyond the job length are held off by dropping room.
    always_comb begin
        in_xfer       = (state_q == S_XFER);
        room          = (beat_cnt_q < beats_q);
        wm_tvalid     = in_xfer && room && s_axis_tvalid[grant_q];
        wm_tdata      = in_xfer ? s_axis_tdata[int'(grant_q)*C_DATA_WIDTH +: C_DATA_WIDTH] : '0;
        s_axis_tready = '0;
        if (in_xfer) begin
            s_axis_tready[grant_q] = wm_tready && room;
        end
        beat_fire  = wm_tvalid && wm_tready;
        beat_cnt_d = beat_cnt_q + SW'(1);
    end

    always_comb begin
        req_ready = (state_q == S_IDLE) ? pick_gnt : '0;
        req_done  = '0;
        if (state_q == S_DONE) begin
            req_done[grant_q] = 1'b1;
        end
    end

    always_ff @(posedge ap_clk) begin
        if (areset) begin
            state_q    <= S_IDLE;
            rr_ptr_q   <= '0;
            grant_q    <= '0;
            addr_q     <= '0;
            size_q     <= '0;
            beats_q    <= '0;
            beat_cnt_q <= '0;
            wm_start_q <= 1'b0;
        end else begin
            wm_start_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        grant_q    <= pick_idx;
                        addr_q     <= sel_addr;
                        size_q     <= sel_size;
                        beats_q    <= beats_d;
                        beat_cnt_q <= '0;
                        if (sel_size == '0) begin
                            state_q <= S_DONE;
                        end else begin
                            state_q    <= S_LAUNCH;
                            wm_start_q <= 1'b1;
                        end
                    end
                end
                S_LAUNCH: state_q <= S_XFER;
                S_XFER: begin
                    if (beat_fire) begin
                        beat_cnt_q <= beat_cnt_d;
                    end
                    if (wm_done) begin
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    rr_ptr_q <= rr_ptr_d;
                    state_q  <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign wm_start = wm_start_q;
    assign wm_addr  = addr_q;
    assign wm_size  = size_q;
    assign busy     = (state_q != S_IDLE);
    assign grant_id = grant_q;

endmodule

// File: tb/tb_cceip_kernel_wr_arbiter.sv
// Directed scenario bench for the CCEIP kernel write arbiter (2 requesters, 64-bit data).
module tb_cceip_kernel_wr_arbiter;

    localparam int N  = 2;
    localparam int AW = 64;
    localparam int SW = 64;
    localparam int DW = 64;

    logic            ap_clk = 1'b0;
    logic            areset;
    logic [N-1:0]    req_valid, req_ready, req_done;
    logic [N*AW-1:0] req_addr;
    logic [N*SW-1:0] req_size;
    logic [N-1:0]    s_axis_tvalid, s_axis_tready;
    logic [N*DW-1:0] s_axis_tdata;
    logic            wm_start;
    logic [AW-1:0]   wm_addr;
    logic [SW-1:0]   wm_size;
    logic            wm_done, wm_tvalid, wm_tready;
    logic [DW-1:0]   wm_tdata;
    logic            busy;
    logic [0:0]      grant_id;

    int total = 0;
    int bad   = 0;
    int start_cnt = 0;
    int done_cnt  = 0;
    logic [DW-1:0] fwd_q[$];
    int            acc_log[$];

    cceip_kernel_wr_arbiter #(
        .NUM_REQ(N), .C_ADDR_WIDTH(AW), .C_XFER_SIZE_WIDTH(SW), .C_DATA_WIDTH(DW)
    ) dut (
        .ap_clk(ap_clk), .areset(areset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_size(req_size), .req_done(req_done),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tdata(s_axis_tdata),
        .wm_start(wm_start), .wm_addr(wm_addr), .wm_size(wm_size), .wm_done(wm_done),
        .wm_tvalid(wm_tvalid), .wm_tready(wm_tready), .wm_tdata(wm_tdata),
        .busy(busy), .grant_id(grant_id)
    );

    always #5 ap_clk = ~ap_clk;

    // Edge monitor: command pulses, completions, forwarded beats, acceptances.
    always @(posedge ap_clk) begin
        if (wm_start) start_cnt++;
        if (|req_done) done_cnt++;
        if (wm_tvalid && wm_tready) fwd_q.push_back(wm_tdata);
        for (int i = 0; i < N; i++) begin
            if (req_valid[i] && req_ready[i]) acc_log.push_back(i);
        end
    end

    function automatic logic [DW-1:0] pat(input int g, input int k);
        return 64'hA5A5_0000_0000_0000 | (64'(g) << 32) | 64'(k);
    endfunction

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic do_reset();
        areset = 1'b1;
        req_valid = '0;
        s_axis_tvalid = '0;
        wm_done = 1'b0;
        wm_tready = 1'b0;
        tick();
        tick();
        areset = 1'b0;
        #1;
    endtask

    // Requester g offers `offer` beats; wm_tready optionally toggles every cycle.
    task automatic feed(input int g, input int offer, input bit toggle, input int cycles);
        int k;
        k = 0;
        for (int c = 0; c < cycles; c++) begin
            wm_tready = toggle ? c[0] : 1'b1;
            s_axis_tvalid[g] = (k < offer);
            s_axis_tdata[g*DW +: DW] = pat(g, k);
            #1;
            if (s_axis_tvalid[g] && s_axis_tready[g]) k++;
            tick();
        end
        s_axis_tvalid[g] = 1'b0;
        wm_tready = 1'b0;
    endtask

    task automatic finish_xfer();
        wm_done = 1'b1;
        tick();
        wm_done = 1'b0;
        #1;
    endtask

    task automatic wait_start(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (wm_start) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        do_reset();
        s_axis_tvalid = '1;
        wm_tready = 1'b1;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %0b want 0", busy); end
        total++; if (wm_start !== 1'b0) begin bad++; $display("FAIL reset_wm_start: got %0b want 0", wm_start); end
        total++; if (req_done !== 2'b00) begin bad++; $display("FAIL reset_req_done: got %b want 00", req_done); end
        total++; if (s_axis_tready !== 2'b00) begin bad++; $display("FAIL reset_tready: got %b want 00", s_axis_tready); end
        total++; if (wm_tvalid !== 1'b0) begin bad++; $display("FAIL reset_wm_tvalid: got %0b want 0", wm_tvalid); end
        total++; if (wm_addr !== 64'h0 || wm_size !== 64'h0) begin bad++; $display("FAIL reset_cmd: got addr %h size %h want 0 0", wm_addr, wm_size); end
        total++; if (grant_id !== 1'b0) begin bad++; $display("FAIL reset_grant_id: got %0d want 0", grant_id); end
        s_axis_tvalid = '0;
        wm_tready = 1'b0;
    endtask

    task automatic test_single();
        int f0;
        int s0;
        req_addr[0 +: AW] = 64'h1000;
        req_size[0 +: SW] = 64'd8;
        req_valid = 2'b01;
        #1;
        total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL single_ready: got %b want 01", req_ready); end
        s0 = start_cnt;
        tick();
        req_valid = 2'b00;
        total++; if (wm_start !== 1'b1) begin bad++; $display("FAIL single_start: got %0b want 1", wm_start); end
        total++; if (wm_addr !== 64'h1000) begin bad++; $display("FAIL single_addr: got %h want 1000", wm_addr); end
        total++; if (wm_size !== 64'd8) begin bad++; $display("FAIL single_size: got %0d want 8", wm_size); end
        total++; if (busy !== 1'b1 || grant_id !== 1'b0) begin bad++; $display("FAIL single_busy_gid: got %0b %0d want 1 0", busy, grant_id); end
        tick();
        total++; if (wm_start !== 1'b0) begin bad++; $display("FAIL single_start_once: got %0b want 0", wm_start); end
        f0 = fwd_q.size();
        feed(0, 1, 1'b0, 3);
        total++; if (fwd_q.size() - f0 != 1) begin bad++; $display("FAIL single_beats: got %0d want 1", fwd_q.size() - f0); end
        else begin
            total++; if (fwd_q[f0] !== pat(0, 0)) begin bad++; $display("FAIL single_data: got %h want %h", fwd_q[f0], pat(0, 0)); end
        end
        finish_xfer();
        total++; if (req_done !== 2'b01) begin bad++; $display("FAIL single_done: got %b want 01", req_done); end
        tick();
        total++; if (req_done !== 2'b00 || busy !== 1'b0) begin bad++; $display("FAIL single_done_once: got done %b busy %0b want 00 0", req_done, busy); end
        total++; if (wm_addr !== 64'h1000) begin bad++; $display("FAIL single_addr_hold: got %h want 1000", wm_addr); end
        total++; if (start_cnt - s0 != 1) begin bad++; $display("FAIL single_start_count: got %0d want 1", start_cnt - s0); end
    endtask

    task automatic test_contention();
        int  f0;
        bit  leak;
        do_reset();
        req_addr = {64'h3000, 64'h2000};
        req_size = {64'd8, 64'd16};
        req_valid = 2'b11;
        #1;
        total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL cont_ready0: got %b want 01", req_ready); end
        tick();
        req_valid = 2'b10;
        total++; if (grant_id !== 1'b0 || wm_addr !== 64'h2000) begin bad++; $display("FAIL cont_first: got gid %0d addr %h want 0 2000", grant_id, wm_addr); end
        tick();
        leak = 1'b0;
        f0 = fwd_q.size();
        s_axis_tvalid[1] = 1'b1;
        s_axis_tdata[DW +: DW] = pat(1, 9);
        for (int c = 0; c < 4; c++) begin
            wm_tready = 1'b1;
            s_axis_tvalid[0] = 1'b1;
            s_axis_tdata[0 +: DW] = pat(0, c);
            #1;
            if (s_axis_tready[1] !== 1'b0) leak = 1'b1;
            tick();
        end
        s_axis_tvalid = '0;
        wm_tready = 1'b0;
        total++; if (leak !== 1'b0) begin bad++; $display("FAIL cont_tready1_low: got %0b want 0", leak); end
        total++; if (fwd_q.size() - f0 != 2) begin bad++; $display("FAIL cont_beats: got %0d want 2", fwd_q.size() - f0); end
        else begin
            total++; if (fwd_q[f0] !== pat(0, 0) || fwd_q[f0+1] !== pat(0, 1)) begin bad++; $display("FAIL cont_data: got %h %h want %h %h", fwd_q[f0], fwd_q[f0+1], pat(0, 0), pat(0, 1)); end
        end
        finish_xfer();
        total++; if (req_done !== 2'b01) begin bad++; $display("FAIL cont_done0: got %b want 01", req_done); end
        total++; if (req_ready !== 2'b00) begin bad++; $display("FAIL cont_no_accept_in_done: got %b want 00", req_ready); end
        tick();
        total++; if (req_ready !== 2'b10) begin bad++; $display("FAIL cont_ready1: got %b want 10", req_ready); end
        tick();
        req_valid = 2'b00;
        total++; if (grant_id !== 1'b1 || wm_addr !== 64'h3000 || wm_start !== 1'b1) begin bad++; $display("FAIL cont_second: got gid %0d addr %h start %0b want 1 3000 1", grant_id, wm_addr, wm_start); end
        tick();
        feed(1, 1, 1'b0, 3);
        finish_xfer();
        total++; if (req_done !== 2'b10) begin bad++; $display("FAIL cont_done1: got %b want 10", req_done); end
        tick();
    endtask

    task automatic test_fairness();
        int a0;
        bit ok;
        do_reset();
        req_size = {64'd8, 64'd8};
        req_addr = {64'h8800, 64'h8000};
        a0 = acc_log.size();
        req_valid = 2'b11;
        for (int j = 0; j < 4; j++) begin
            wait_start(ok);
            total++; if (!ok) begin bad++; $display("FAIL fair_start_timeout: job %0d got no wm_start want pulse", j); end
            tick();
            feed(int'(grant_id), 1, 1'b0, 2);
            finish_xfer();
            tick();
        end
        req_valid = 2'b00;
        total++; if (acc_log.size() - a0 != 4) begin bad++; $display("FAIL fair_count: got %0d want 4", acc_log.size() - a0); end
        else begin
            for (int j = 0; j < 4; j++) begin
                total++; if (acc_log[a0+j] != (j % 2)) begin bad++; $display("FAIL fair_order: job %0d got %0d want %0d", j, acc_log[a0+j], j % 2); end
            end
        end
        tick();
        tick();
    endtask

    task automatic test_zero();
        int s0;
        s0 = start_cnt;
        req_addr[AW +: AW] = 64'h5000;
        req_size[SW +: SW] = 64'd0;
        req_valid = 2'b10;
        #1;
        total++; if (req_ready !== 2'b10) begin bad++; $display("FAIL zero_ready: got %b want 10", req_ready); end
        tick();
        req_valid = 2'b00;
        total++; if (req_done !== 2'b10 || wm_start !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL zero_done: got done %b start %0b busy %0b want 10 0 1", req_done, wm_start, busy); end
        tick();
        total++; if (req_done !== 2'b00 || busy !== 1'b0) begin bad++; $display("FAIL zero_idle: got done %b busy %0b want 00 0", req_done, busy); end
        total++; if (start_cnt != s0) begin bad++; $display("FAIL zero_no_start: got %0d starts want 0", start_cnt - s0); end
    endtask

    task automatic test_overrun();
        int f0;
        do_reset();
        req_addr[0 +: AW] = 64'h4000;
        req_size[0 +: SW] = 64'd20;
        req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        total++; if (wm_size !== 64'd20 || wm_addr !== 64'h4000) begin bad++; $display("FAIL ovr_cmd: got addr %h size %0d want 4000 20", wm_addr, wm_size); end
        tick();
        f0 = fwd_q.size();
        feed(0, 5, 1'b1, 14);
        total++; if (fwd_q.size() - f0 != 3) begin bad++; $display("FAIL ovr_beats: got %0d want 3", fwd_q.size() - f0); end
        else begin
            for (int k = 0; k < 3; k++) begin
                total++; if (fwd_q[f0+k] !== pat(0, k)) begin bad++; $display("FAIL ovr_data: beat %0d got %h want %h", k, fwd_q[f0+k], pat(0, k)); end
            end
        end
        finish_xfer();
        total++; if (req_done !== 2'b01) begin bad++; $display("FAIL ovr_done: got %b want 01", req_done); end
        tick();
    endtask

    task automatic test_reset_mid();
        int d0;
        do_reset();
        req_addr = {64'h7000, 64'h6000};
        req_size = {64'd32, 64'd8};
        req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        tick();
        feed(0, 1, 1'b0, 2);
        finish_xfer();
        tick();
        req_valid = 2'b10;
        tick();
        req_valid = 2'b00;
        tick();
        d0 = done_cnt;
        s_axis_tvalid[1] = 1'b1;
        s_axis_tdata[DW +: DW] = pat(1, 0);
        wm_tready = 1'b1;
        tick();
        areset = 1'b1;
        tick();
        total++; if (busy !== 1'b0 || wm_start !== 1'b0 || req_done !== 2'b00) begin bad++; $display("FAIL rst_mid_ctrl: got busy %0b start %0b done %b want 0 0 00", busy, wm_start, req_done); end
        total++; if (wm_tvalid !== 1'b0 || s_axis_tready !== 2'b00) begin bad++; $display("FAIL rst_mid_stream: got tvalid %0b tready %b want 0 00", wm_tvalid, s_axis_tready); end
        total++; if (wm_addr !== 64'h0 || wm_size !== 64'h0 || grant_id !== 1'b0) begin bad++; $display("FAIL rst_mid_cmd: got %h %h %0d want 0 0 0", wm_addr, wm_size, grant_id); end
        areset = 1'b0;
        s_axis_tvalid = '0;
        wm_tready = 1'b0;
        tick();
        total++; if (done_cnt != d0) begin bad++; $display("FAIL rst_mid_no_done: got %0d pulses want 0", done_cnt - d0); end
        req_size = {64'd8, 64'd8};
        req_valid = 2'b11;
        #1;
        total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL rst_mid_restart: got %b want 01", req_ready); end
        tick();
        req_valid = 2'b00;
        total++; if (grant_id !== 1'b0 || wm_start !== 1'b1) begin bad++; $display("FAIL rst_mid_grant: got gid %0d start %0b want 0 1", grant_id, wm_start); end
        tick();
        feed(0, 1, 1'b0, 2);
        finish_xfer();
        total++; if (req_done !== 2'b01) begin bad++; $display("FAIL rst_mid_done: got %b want 01", req_done); end
        tick();
    endtask

    initial begin
        areset = 1'b1;
        req_valid = '0;
        req_addr = '0;
        req_size = '0;
        s_axis_tvalid = '0;
        s_axis_tdata = '0;
        wm_done = 1'b0;
        wm_tready = 1'b0;
        test_reset();
        test_single();
        test_contention();
        test_fairness();
        test_zero();
        test_overrun();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/cceip_kernel_wr_arbiter.md
CCEIP_KERNEL_WR_ARBITER -- requirements
Module: cceip_kernel_wr_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 2, number of write requesters (2..8).
REQ-002 SHALL have parameter C_ADDR_WIDTH, default 64, write address width.
REQ-003 SHALL have parameter C_XFER_SIZE_WIDTH, default 64, byte-count width.
REQ-004 SHALL have parameter C_DATA_WIDTH, default 64, stream data width.
REQ-005 SHALL have port ap_clk  in  1  the single clock; all logic is on the rising edge.
REQ-006 SHALL have port areset  in  1  synchronous, active-high reset.
REQ-007 SHALL have port req_valid  in  NUM_REQ  per-requester transfer request.
REQ-008 SHALL have port req_ready  out  NUM_REQ  per-requester request accept.
REQ-009 SHALL have port req_addr  in  NUM_REQ*C_ADDR_WIDTH  per-requester destination byte address.
REQ-010 SHALL have port req_size  in  NUM_REQ*C_XFER_SIZE_WIDTH  per-requester byte count.
REQ-011 SHALL have port req_done  out  NUM_REQ  one-cycle completion pulse per requester.
REQ-012 SHALL have port s_axis_tvalid / s_axis_tready / s_axis_tdata  in / out / in  NUM_REQ / NUM_REQ / NUM_REQ*C_DATA_WIDTH  per-requester write-data stream.
REQ-013 SHALL have port wm_start / wm_addr / wm_size  out  1 / C_ADDR_WIDTH / C_XFER_SIZE_WIDTH  command to the shared AXI write master.
REQ-014 SHALL have port wm_done  in  1  completion pulse from the write master.
REQ-015 SHALL have port wm_tvalid / wm_tready / wm_tdata  out / in / out  1 / 1 / C_DATA_WIDTH  data stream to the write master.
REQ-016 SHALL have port busy  out  1 (high outside S_IDLE) and grant_id  out  $clog2(NUM_REQ) (current owner).

Function
REQ-017 SHALL implement states S_IDLE, S_LAUNCH, S_XFER, S_DONE.
REQ-018 In S_IDLE, SHALL grant the first index at or after rr_ptr, wrapping, with req_valid set; req_ready of that index only is high combinationally; acceptance = valid & ready.
REQ-019 On acceptance at cycle T, SHALL register addr, size and grant_id; then wm_start=1 for exactly cycle T+1 (S_LAUNCH), with wm_addr/wm_size stable from T+1 until the next acceptance.
REQ-020 Zero-byte request SHALL skip S_LAUNCH/S_XFER: S_IDLE -> S_DONE; wm_start is never asserted for it.
REQ-021 S_LAUNCH -> S_XFER unconditionally; S_XFER -> S_DONE on wm_done; S_DONE -> S_IDLE after one cycle.
REQ-022 In S_XFER, SHALL route the granted stream: wm_tvalid=s_axis_tvalid[g] & room, s_axis_tready[g]=wm_tready & room, wm_tdata=s_axis_tdata[g]; all other tready are 0.
REQ-023 Beat counter SHALL count wm_tvalid & wm_tready; expected beats = ceil(size / (C_DATA_WIDTH/8)); room = count < expected; beats beyond expected are not accepted.
REQ-024 Outside S_XFER, all s_axis_tready and wm_tvalid SHALL be 0; wm_tdata is don't-care (driven 0).
REQ-025 In S_DONE, req_done[grant_id] SHALL pulse for one cycle and rr_ptr becomes (grant_id+1) mod NUM_REQ.
REQ-026 wm_done outside S_XFER SHALL be ignored.
REQ-027 req_valid changes after acceptance SHALL not affect the active transfer.
REQ-028 No request SHALL be accepted in the cycle req_done is pulsed (S_DONE); the earliest next acceptance is the following cycle.

Reset
REQ-029 On areset: state S_IDLE, rr_ptr 0, beat counter 0, grant_id 0, and wm_start, req_ready, req_done, s_axis_tready, wm_tvalid, busy all 0; wm_addr/wm_size 0.
REQ-030 Reset mid-transfer SHALL abandon the transfer with no req_done; the write master shares areset.

Structure
REQ-031 State enum and the bytes-per-beat constant SHALL be in the shared package cceip_kernel_pkg.
REQ-032 The round-robin pick SHALL be the sub-module cceip_kernel_rr_pick (request vector, pointer -> one-hot grant, index, any).

Verification
REQ-033 Single request: req0 addr 0x1000, size 8 -> wm_start at T+1, wm_addr 0x1000, wm_size 8, one beat forwarded, wm_done -> req_done[0] one cycle later.
REQ-034 Contention: req0 and req1 valid together, rr_ptr 0 -> req0 served first, then req1; s_axis_tready[1]=0 throughout req0's S_XFER.
REQ-035 Fairness: both requesters continuously valid for 4 jobs -> grant order 0,1,0,1.
REQ-036 Zero size: req1 size 0 -> req_done[1] pulsed, wm_start never high.
REQ-037 Overrun/backpressure: size 20 (3 beats), requester offers 5 beats, wm_tready toggling -> exactly 3 beats forwarded, data order preserved.
REQ-038 Reset mid-S_XFER -> next cycle all outputs 0, busy 0, no req_done; a new request is then served from rr_ptr 0.
